dac_sample_analyzer: RTL and testbench
======================================

# dac_sample_analyzer

Receive-side measurement block for the function generator's DAC sample stream. It consumes the same sample words the generator drives toward the DAC. It detects rising mid-scale crossings with hysteresis and reports the period (in sys_clk cycles), minimum and maximum of each complete waveform cycle. It sits on the loopback path beside the generator, used for self-check on hardware and as a bench monitor.

## Interface
- DATA_W, 8, sample width; mid-scale MID = 2^(DATA_W-1)
- PERIOD_W, 24, period counter width
- HYST, 4, hysteresis half-band in LSBs; legal range 1..MID-1
- sys_clk_i  in  1  system clock, all logic on rising edge
- sys_rst_i  in  1  reset; one clock; reset is asynchronous and active-high
- sample_i  in  DATA_W  unsigned sample, sampled only when sample_valid_i=1
- sample_valid_i  in  1  sample qualifier, any duty/gap pattern
- period_o  out  PERIOD_W  clocks between last two accepted rising crossings; reset 0
- min_o  out  DATA_W  minimum sample of last measured cycle; reset 0
- max_o  out  DATA_W  maximum sample of last measured cycle; reset 0
- meas_valid_o  out  1  one-cycle pulse when period_o/min_o/max_o update; reset 0
- timeout_o  out  1  one-cycle pulse on counter saturation; reset 0
- locked_o  out  1  high while a period is being timed (MEAS_LO/MEAS_HI); reset 0

## Operation
- Thresholds: TH_HI = MID+HYST, TH_LO = MID-HYST. "Low" = sample <= TH_LO; "high" = sample >= TH_HI; samples between are ignored for state decisions.
- States: ARM, WAIT_RISE, MEAS_LO, MEAS_HI. Reset state ARM.
- ARM: valid low sample -> WAIT_RISE.
- WAIT_RISE: valid high sample (first crossing) -> MEAS_LO; cnt <= 1; min/max trackers seeded with that sample.
- MEAS_LO: valid low sample -> MEAS_HI.
- MEAS_HI: valid high sample = crossing -> publish: period_o <= cnt, min_o/max_o <= tracker values (crossing sample excluded); meas_valid_o pulses; cnt <= 1; trackers reseeded with crossing sample; stay measuring (-> MEAS_LO).
- In MEAS_LO/MEAS_HI, every valid non-crossing sample updates trackers (min = smaller, max = larger).
- cnt increments every clock in MEAS_LO/MEAS_HI regardless of valid. If cnt = 2^PERIOD_W-1 and no crossing on that edge: timeout_o pulses, -> ARM, outputs period_o/min_o/max_o hold, no publish.
- A crossing on the saturating edge publishes normally (crossing wins).
- Reset mid-operation: all state, counters, trackers, outputs to reset values immediately; no partial publish.
- Signals during meas_valid_o are stable until the next publish.

## Timing
- Crossing sample accepted on edge t1 (sample_valid_i=1 before edge): period_o/min_o/max_o/meas_valid_o valid after edge t1, i.e. one cycle after the sample is presented.
- Period: crossings accepted at edges t0 and t1 -> period_o = t1 - t0.
- locked_o rises after the first-crossing edge, falls after the timeout edge.
- meas_valid_o and timeout_o never assert in the same cycle.
- No backpressure: every valid sample is consumed on its edge.

## Test plan
- Square wave 0x20/0xE0, 50 clocks each, valid every clock -> after 2nd rise meas_valid_o pulses; period_o=100, min_o=0x20, max_o=0xE0, repeats every 100 clocks.
- Samples every 4th clock, triangle 0x10..0xF0 period 256 samples -> period_o=1024, min_o=0x10, max_o=0xF0.
- Noise 0x7D..0x83 around MID with HYST=4 -> no meas_valid_o, state never leaves ARM/WAIT_RISE.
- PERIOD_W=8: low, rise, then constant 0xFF -> timeout_o pulse 255 clocks after rise, locked_o=0, prior outputs unchanged.
- Crossing exactly on the saturating edge with PERIOD_W=8 -> meas_valid_o pulse, period_o=255, no timeout_o.
- Assert sys_rst_i asynchronously in MEAS_HI -> all outputs 0 immediately; next valid measurement requires fresh low, rise, low, rise.

Source files
------------

// File: rtl/dac_sample_analyzer.sv
// Measures period, minimum and maximum of each cycle of the DAC sample stream,
// timing between rising mid-scale crossings qualified by a hysteresis band.
module dac_sample_analyzer #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned PERIOD_W = 24,
   parameter int unsigned HYST     = 4
) (
   input  logic                sys_clk_i,
   input  logic                sys_rst_i,
   input  logic [DATA_W-1:0]   sample_i,
   input  logic                sample_valid_i,
   output logic [PERIOD_W-1:0] period_o,
   output logic [DATA_W-1:0]   min_o,
   output logic [DATA_W-1:0]   max_o,
   output logic                meas_valid_o,
   output logic                timeout_o,
   output logic                locked_o
);

   localparam int unsigned Mid = 1 << (DATA_W - 1);
   localparam logic [DATA_W-1:0] ThHi = DATA_W'(Mid + HYST);
   localparam logic [DATA_W-1:0] ThLo = DATA_W'(Mid - HYST);

   localparam logic [1:0] ST_ARM       = 2'd0;
   localparam logic [1:0] ST_WAIT_RISE = 2'd1;
   localparam logic [1:0] ST_MEAS_LO   = 2'd2;
   localparam logic [1:0] ST_MEAS_HI   = 2'd3;

   logic [1:0]          state_q, state_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0]   trk_min_q, trk_min_d;
   logic [DATA_W-1:0]   trk_max_q, trk_max_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [DATA_W-1:0]   min_q, min_d;
   logic [DATA_W-1:0]   max_q, max_d;
   logic                meas_valid_q, meas_valid_d;
   logic                timeout_q, timeout_d;

   logic is_lo, is_hi, crossing, cnt_sat;

   assign is_lo    = sample_valid_i && (sample_i <= ThLo);
   assign is_hi    = sample_valid_i && (sample_i >= ThHi);
   assign crossing = (state_q == ST_MEAS_HI) && is_hi;
   assign cnt_sat  = (cnt_q == {PERIOD_W{1'b1}});

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      trk_min_d    = trk_min_q;
      trk_max_d    = trk_max_q;
      period_d     = period_q;
      min_d        = min_q;
      max_d        = max_q;
      meas_valid_d = 1'b0;
      timeout_d    = 1'b0;
      case (state_q)
         ST_ARM: begin
            if (is_lo) state_d = ST_WAIT_RISE;
         end
         ST_WAIT_RISE: begin
            if (is_hi) begin
               state_d   = ST_MEAS_LO;
               cnt_d     = PERIOD_W'(1);
               trk_min_d = sample_i;
               trk_max_d = sample_i;
            end
         end
         default: begin
            if (crossing) begin
               // Crossing sample closes this cycle and seeds the next one.
               period_d     = cnt_q;
               min_d        = trk_min_q;
               max_d        = trk_max_q;
               meas_valid_d = 1'b1;
               cnt_d        = PERIOD_W'(1);
               trk_min_d    = sample_i;
               trk_max_d    = sample_i;
               state_d      = ST_MEAS_LO;
            end else begin
               if (sample_valid_i) begin
                  if (sample_i < trk_min_q) trk_min_d = sample_i;
                  if (sample_i > trk_max_q) trk_max_d = sample_i;
               end
               if ((state_q == ST_MEAS_LO) && is_lo) state_d = ST_MEAS_HI;
               if (cnt_sat) begin
                  timeout_d = 1'b1;
                  state_d   = ST_ARM;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         state_q      <= ST_ARM;
         cnt_q        <= '0;
         trk_min_q    <= '0;
         trk_max_q    <= '0;
         period_q     <= '0;
         min_q        <= '0;
         max_q        <= '0;
         meas_valid_q <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         trk_min_q    <= trk_min_d;
         trk_max_q    <= trk_max_d;
         period_q     <= period_d;
         min_q        <= min_d;
         max_q        <= max_d;
         meas_valid_q <= meas_valid_d;
         timeout_q    <= timeout_d;
      end
   end

   assign period_o     = period_q;
   assign min_o        = min_q;
   assign max_o        = max_q;
   assign meas_valid_o = meas_valid_q;
   assign timeout_o    = timeout_q;
   assign locked_o     = (state_q == ST_MEAS_LO) || (state_q == ST_MEAS_HI);

endmodule

// File: tb/tb_dac_sample_analyzer.sv
// Directed bench for dac_sample_analyzer: a default instance (PERIOD_W=24) and
// a narrow-counter instance (PERIOD_W=8) share the same stimulus.
module tb_dac_sample_analyzer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  sample = 8'h00;
   logic        valid = 1'b0;

   logic [23:0] period_a;
   logic [7:0]  min_a, max_a;
   logic        mv_a, to_a, lk_a;
   logic [7:0]  period_b;
   logic [7:0]  min_b, max_b;
   logic        mv_b, to_b, lk_b;

   int n_checks = 0;
   int n_fail   = 0;
   int both_a   = 0;
   int both_b   = 0;
   int edge_n;
   int pulses;
   int touts;
   int lk_seen;

   always #5 clk = ~clk;

   dac_sample_analyzer dut (
      .sys_clk_i      (clk),
      .sys_rst_i      (rst),
      .sample_i       (sample),
      .sample_valid_i (valid),
      .period_o       (period_a),
      .min_o          (min_a),
      .max_o          (max_a),
      .meas_valid_o   (mv_a),
      .timeout_o      (to_a),
      .locked_o       (lk_a)
   );

   dac_sample_analyzer #(.PERIOD_W(8)) dut8 (
      .sys_clk_i      (clk),
      .sys_rst_i      (rst),
      .sample_i       (sample),
      .sample_valid_i (valid),
      .period_o       (period_b),
      .min_o          (min_b),
      .max_o          (max_b),
      .meas_valid_o   (mv_b),
      .timeout_o      (to_b),
      .locked_o       (lk_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one sample for one clock; outputs are examined at the following negedge.
   task automatic cyc(input logic [7:0] s, input logic v);
      sample = s;
      valid  = v;
      @(posedge clk);
      @(negedge clk);
      edge_n++;
      if (mv_a && to_a) both_a++;
      if (mv_b && to_b) both_b++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      edge_n = 0;
   endtask

   function automatic logic [7:0] tri_v(input int k);
      if (k <= 128) return 8'(16 + (k * 224) / 128);
      return 8'(16 + ((256 - k) * 224) / 128);
   endfunction

   initial begin
      // Reset values
      do_reset();
      chk("rst_period", 32'(period_a), 32'h0);
      chk("rst_min", 32'(min_a), 32'h0);
      chk("rst_max", 32'(max_a), 32'h0);
      chk("rst_flags", {29'h0, mv_a, to_a, lk_a}, 32'h0);

      // Square wave 0x20/0xE0, 50 clocks each; rises at edges 51, 151, 251
      pulses = 0;
      for (int i = 0; i < 300; i++) begin
         cyc((((i / 50) % 2) != 0) ? 8'hE0 : 8'h20, 1'b1);
         if (mv_a) pulses++;
         if (edge_n == 50) chk("sq_unlocked", 32'(lk_a), 32'h0);
         if (edge_n == 51) chk("sq_locked", {30'h0, lk_a, mv_a}, 32'h2);
         if (edge_n == 151 || edge_n == 251) begin
            chk("sq_mv", 32'(mv_a), 32'h1);
            chk("sq_period", 32'(period_a), 32'd100);
            chk("sq_min", 32'(min_a), 32'h20);
            chk("sq_max", 32'(max_a), 32'hE0);
         end
      end
      chk("sq_pulses", 32'(pulses), 32'd2);

      // Triangle, one valid sample every 4th clock, 256 samples per period
      do_reset();
      pulses = 0;
      for (int s = 0; s < 768; s++) begin
         cyc(tri_v(s % 256), 1'b1);
         if (mv_a) pulses++;
         for (int g = 0; g < 3; g++) begin
            cyc(8'($urandom), 1'b0);
            if (mv_a) begin
               pulses++;
               chk("tri_misaligned_pulse", 32'(mv_a), 32'h0);
            end
         end
         if (mv_a || (s % 256 == 67 && s > 255)) begin
            chk("tri_period", 32'(period_a), 32'd1024);
            chk("tri_min", 32'(min_a), 32'h10);
            chk("tri_max", 32'(max_a), 32'hF0);
         end
      end
      chk("tri_pulses", 32'(pulses), 32'd2);

      // Noise inside the hysteresis band never arms or locks
      do_reset();
      pulses = 0;
      lk_seen = 0;
      for (int i = 0; i < 200; i++) begin
         cyc(8'(8'h7D + ($urandom % 7)), 1'($urandom % 2 == 0 || i % 3 == 0));
         if (mv_a) pulses++;
         if (lk_a) lk_seen++;
      end
      chk("noise_pulses", 32'(pulses), 32'd0);
      chk("noise_locked", 32'(lk_seen), 32'd0);

      // PERIOD_W=8 timeout: publish once (period 10), then hold 0xFF from edge 17
      do_reset();
      pulses = 0;
      touts = 0;
      for (int i = 0; i < 5; i++) cyc(8'h20, 1'b1);
      for (int i = 0; i < 5; i++) cyc(8'hE0, 1'b1);
      for (int i = 0; i < 5; i++) cyc(8'h20, 1'b1);
      cyc(8'hE0, 1'b1);
      chk("to_pre_mv", 32'(mv_b), 32'h1);
      chk("to_pre_period", 32'(period_b), 32'd10);
      for (int i = 0; i < 284; i++) begin
         cyc(8'hFF, 1'b1);
         if (mv_b) pulses++;
         if (to_b) touts++;
         if (edge_n == 270) chk("to_before", {30'h0, lk_b, to_b}, 32'h2);
         if (edge_n == 271) begin
            chk("to_pulse", {30'h0, lk_b, to_b}, 32'h1);
            chk("to_hold_period", 32'(period_b), 32'd10);
            chk("to_hold_min", 32'(min_b), 32'h20);
            chk("to_hold_max", 32'(max_b), 32'hE0);
         end
      end
      chk("to_count", 32'(touts), 32'd1);
      chk("to_no_mv", 32'(pulses), 32'd0);

      // PERIOD_W=8: crossing on the saturating edge (rise edge 2, crossing edge 257)
      do_reset();
      touts = 0;
      cyc(8'h20, 1'b1);
      cyc(8'hE0, 1'b1);
      for (int i = 0; i < 254; i++) begin
         cyc(8'h20, 1'b1);
         if (to_b) touts++;
      end
      cyc(8'hE0, 1'b1);
      chk("sat_mv", {30'h0, mv_b, to_b}, 32'h2);
      chk("sat_period", 32'(period_b), 32'd255);
      chk("sat_min", 32'(min_b), 32'h20);
      chk("sat_max", 32'(max_b), 32'hE0);
      chk("sat_locked", 32'(lk_b), 32'h1);
      chk("sat_no_early_to", 32'(touts), 32'd0);

      // Asynchronous reset while in MEAS_HI after one publish
      do_reset();
      for (int i = 0; i < 5; i++) cyc(8'h20, 1'b1);
      for (int i = 0; i < 5; i++) cyc(8'hE0, 1'b1);
      for (int i = 0; i < 5; i++) cyc(8'h20, 1'b1);
      cyc(8'hE0, 1'b1);
      chk("ar_pre_period", 32'(period_a), 32'd10);
      for (int i = 0; i < 3; i++) cyc(8'hE0, 1'b1);
      for (int i = 0; i < 5; i++) cyc(8'h20, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("ar_period", 32'(period_a), 32'h0);
      chk("ar_minmax", {16'h0, min_a, max_a}, 32'h0);
      chk("ar_flags", {29'h0, mv_a, to_a, lk_a}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      edge_n = 0;
      lk_seen = 0;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         cyc(8'hE0, 1'b1);
         if (lk_a) lk_seen++;
      end
      chk("ar_needs_low", 32'(lk_seen), 32'd0);
      for (int i = 0; i < 5; i++) cyc(8'h20, 1'b1);
      for (int i = 0; i < 5; i++) begin
         cyc(8'hE0, 1'b1);
         if (mv_a) pulses++;
      end
      chk("ar_relocked", 32'(lk_a), 32'h1);
      for (int i = 0; i < 5; i++) begin
         cyc(8'h20, 1'b1);
         if (mv_a) pulses++;
      end
      chk("ar_no_partial", 32'(pulses), 32'd0);
      cyc(8'hE0, 1'b1);
      chk("ar_mv", 32'(mv_a), 32'h1);
      chk("ar_period2", 32'(period_a), 32'd10);

      chk("mv_to_overlap_a", 32'(both_a), 32'd0);
      chk("mv_to_overlap_b", 32'(both_b), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
